// File: rtl/mux_nne1_rr_if.sv
// ---------------------------------------------------------------------------
// mux_nne1_rr_if
// Bus bundle for the N-to-1 registered selector.
//   in_data   N*WIDTH  channel data, channel i in in_data[i*WIDTH +: WIDTH]
//   in_valid  N        channel i has data
//   in_ready  N        channel i is accepted this cycle (one-hot or zero)
//   sel       SELW     explicit channel index (explicit-select mode only)
//   out_data  WIDTH    registered selected data
//   out_valid 1        out_data holds an untaken item
//   out_ready 1        consumer takes out_data this cycle
//   grant     SELW     index of the channel whose data is in out_data
// slave  : the selector itself.
// master : producers plus consumer (everything around the selector).
// ---------------------------------------------------------------------------
interface mux_nne1_rr_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4
);
  localparam int SELW = $clog2(N);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [SELW-1:0]    sel;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SELW-1:0]    grant;

  modport slave (
    input  in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_valid, grant
  );

  modport master (
    output in_data, in_valid, sel, out_ready,
    input  in_ready, out_data, out_valid, grant
  );
endinterface

// File: rtl/mux_nne1_rr.sv
// ---------------------------------------------------------------------------
// mux_nne1_rr
// Registered N-to-1 selector with valid/ready on every input channel and on
// the output. A one-entry output buffer gives 1 item/cycle throughput under
// back-pressure-free operation and holds its contents while stalled.
//   MODE = 0 : bus.sel picks the channel; an out-of-range sel selects nothing.
//   MODE = 1 : round-robin among valid channels starting at an internal
//              pointer, which advances past the winner on every transfer.
// Ports:
//   clk_i   clock, all state updates on the rising edge
//   rst_ni  asynchronous active-low reset
//   bus     mux_nne1_rr_if.slave (see interface header for signal list)
// ---------------------------------------------------------------------------
module mux_nne1_rr #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int MODE  = 0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  mux_nne1_rr_if.slave bus
);
  localparam int SELW = $clog2(N);

  // Output buffer and arbitration state
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  grant_q, grant_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  // Candidate channel for this cycle
  logic             load;
  logic             cand_ok;
  logic [SELW-1:0]  cand;
  logic             cand_valid;
  logic [WIDTH-1:0] cand_data;
  logic             xfer;
  int               idx;

  // Buffer can accept a new item when empty or being drained this cycle.
  assign load = ~out_valid_q | bus.out_ready;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    cand    = '0;
    cand_ok = 1'b0;
    idx     = 0;
    if (MODE == 0) begin
      cand    = bus.sel;
      cand_ok = int'({1'b0, bus.sel}) < N;
    end else begin
      // Scan ptr, ptr+1, ... with explicit wrap so non-power-of-2 N never
      // visits a nonexistent channel.
      for (int k = 0; k < N; k++) begin
        idx = int'({1'b0, ptr_q}) + k;
        if (idx >= N) idx = idx - N;
        if (!cand_ok && bus.in_valid[idx]) begin
          cand_ok = 1'b1;
          cand    = SELW'(idx);
        end
      end
    end
  end

  // Data/valid of the candidate, plus the ready strobe back to it.
  always_comb begin
    cand_valid   = 1'b0;
    cand_data    = '0;
    bus.in_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (cand == SELW'(i)) begin
        cand_valid = bus.in_valid[i];
        cand_data  = bus.in_data[i*WIDTH +: WIDTH];
      end
      bus.in_ready[i] = load & cand_ok & (cand == SELW'(i));
    end
  end

  assign xfer = load & cand_ok & cand_valid;

  always_comb begin
    out_d       = out_q;
    grant_d     = grant_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_d       = cand_data;
      grant_d     = cand;
      out_valid_d = 1'b1;
      if (MODE != 0) ptr_d = (cand == SELW'(N - 1)) ? '0 : cand + 1'b1;
    end else if (bus.out_ready) begin
      // Drain without reload: data and grant keep their last values.
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      grant_q     <= '0;
      ptr_q       <= '0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_data  = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.grant     = grant_q;

endmodule

// File: tb/tb_mux_nne1_rr.sv
// ---------------------------------------------------------------------------
// tb_mux_nne1_rr
// Four selector instances (WIDTH=8) driven side by side:
//   0: N=4 explicit select   1: N=4 round-robin
//   2: N=3 round-robin       3: N=3 explicit select (sel=3 is out of range)
// A reference model predicts in_ready every cycle and queues each accepted
// item; per-instance monitors pop and compare whenever the output is taken.
// ---------------------------------------------------------------------------
module tb_mux_nne1_rr;
  localparam int NCFG = 4;
  localparam int N_CFG    [NCFG] = '{4, 4, 3, 3};
  localparam int MODE_CFG [NCFG] = '{0, 1, 1, 0};

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] grant;
  } item_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Stimulus, widest-case shaped, sliced per instance
  logic [31:0] tb_data   [NCFG];
  logic [3:0]  tb_valid  [NCFG];
  logic [1:0]  tb_sel    [NCFG];
  logic        tb_oready [NCFG];
  // Observed outputs
  wire  [3:0]  tb_iready [NCFG];
  wire  [7:0]  tb_out    [NCFG];
  wire         tb_ovalid [NCFG];
  wire  [1:0]  tb_grant  [NCFG];

  // Reference model state
  item_t exp_q  [NCFG][$];
  bit    m_full [NCFG];
  int    m_ptr  [NCFG];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int NG = N_CFG[g];
    localparam int SG = $clog2(NG);

    mux_nne1_rr_if #(.WIDTH(8), .N(NG)) u_if ();

    mux_nne1_rr #(.WIDTH(8), .N(NG), .MODE(MODE_CFG[g])) u_dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (u_if.slave)
    );

    assign u_if.in_data   = tb_data[g][NG*8-1:0];
    assign u_if.in_valid  = tb_valid[g][NG-1:0];
    assign u_if.sel       = tb_sel[g][SG-1:0];
    assign u_if.out_ready = tb_oready[g];
    assign tb_iready[g]   = 4'(u_if.in_ready);
    assign tb_out[g]      = u_if.out_data;
    assign tb_ovalid[g]   = u_if.out_valid;
    assign tb_grant[g]    = 2'(u_if.grant);

    // Monitor: whenever the consumer takes an item, it must be the oldest
    // item the model accepted.
    always @(negedge clk) begin
      item_t it;
      if (rst_n && tb_ovalid[g] && tb_oready[g]) begin
        if (exp_q[g].size() == 0) begin
          check($sformatf("sb_unexpected_item[%0d]", g), 32'd1, 32'd0);
        end else begin
          it = exp_q[g].pop_front();
          check($sformatf("sb_data[%0d]", g), 32'(tb_out[g]), 32'(it.data));
          check($sformatf("sb_grant[%0d]", g), 32'(tb_grant[g]), 32'(it.grant));
        end
      end
    end
  end

  // Reference model for one cycle of instance k, evaluated before the edge.
  task automatic model_eval(input int k);
    int         n;
    int         c;
    bit         load;
    logic [3:0] exp_rdy;
    n       = N_CFG[k];
    c       = -1;
    exp_rdy = '0;
    load    = !m_full[k] || tb_oready[k];
    if (MODE_CFG[k] == 0) begin
      if (int'(tb_sel[k]) < n) c = int'(tb_sel[k]);
    end else begin
      for (int j = 0; j < n; j++) begin
        int p;
        p = (m_ptr[k] + j) % n;
        if (c < 0 && tb_valid[k][p]) c = p;
      end
    end
    check($sformatf("out_valid[%0d]", k), 32'(tb_ovalid[k]), 32'(m_full[k]));
    if (c >= 0 && load) exp_rdy[c] = 1'b1;
    check($sformatf("in_ready[%0d]", k), 32'(tb_iready[k]), 32'(exp_rdy));
    if (c >= 0 && load && tb_valid[k][c]) begin
      exp_q[k].push_back('{data: tb_data[k][c*8 +: 8], grant: 2'(c)});
      m_full[k] = 1'b1;
      m_ptr[k]  = (c + 1) % n;
    end else if (tb_oready[k]) begin
      m_full[k] = 1'b0;
    end
  endtask

  // One clock: model evaluates mid-cycle, returns 1 time unit after the edge.
  task automatic cycle();
    @(negedge clk);
    for (int k = 0; k < NCFG; k++) model_eval(k);
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NCFG; k++) begin
      m_full[k] = 1'b0;
      m_ptr[k]  = 0;
      exp_q[k].delete();
    end
  endtask

  task automatic idle_all();
    for (int k = 0; k < NCFG; k++) begin
      tb_valid[k]  = '0;
      tb_sel[k]    = '0;
      tb_oready[k] = 1'b1;
    end
  endtask

  initial begin
    for (int k = 0; k < NCFG; k++) tb_data[k] = '0;
    idle_all();
    model_reset();

    // Reset and idle
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NCFG; k++) begin
      check($sformatf("rst_out[%0d]", k), 32'(tb_out[k]), 32'h0);
      check($sformatf("rst_valid[%0d]", k), 32'(tb_ovalid[k]), 32'h0);
      check($sformatf("rst_grant[%0d]", k), 32'(tb_grant[k]), 32'h0);
    end
    check("rst_rr_ready", 32'(tb_iready[1]), 32'h0);
    rst_n = 1'b1;
    repeat (2) cycle();
    check("idle_out", 32'(tb_out[0]), 32'h0);
    check("idle_valid", 32'(tb_ovalid[0]), 32'h0);

    // Explicit select
    tb_sel[0]   = 2'd2;
    tb_data[0]  = 32'h00A5_0000;
    tb_valid[0] = 4'b0100;
    #1;
    check("sel_ready", 32'(tb_iready[0]), 32'h4);
    cycle();
    check("sel_out", 32'(tb_out[0]), 32'hA5);
    check("sel_grant", 32'(tb_grant[0]), 32'd2);
    check("sel_valid", 32'(tb_ovalid[0]), 32'd1);
    tb_sel[0] = 2'd3;
    #1;
    check("unsel_ready2", 32'(tb_iready[0][2]), 32'd0);
    cycle();
    check("unsel_drained", 32'(tb_ovalid[0]), 32'd0);
    check("unsel_out_hold", 32'(tb_out[0]), 32'hA5);

    // Back-pressure
    tb_sel[0]    = 2'd0;
    tb_data[0]   = 32'h11;
    tb_valid[0]  = 4'b0001;
    tb_oready[0] = 1'b0;
    cycle();
    check("bp_first", 32'(tb_out[0]), 32'h11);
    tb_data[0] = 32'h22;
    repeat (5) begin
      cycle();
      check("bp_hold", 32'(tb_out[0]), 32'h11);
      check("bp_ready", 32'(tb_iready[0]), 32'h0);
    end
    tb_oready[0] = 1'b1;
    cycle();
    check("bp_nobubble_out", 32'(tb_out[0]), 32'h22);
    check("bp_nobubble_valid", 32'(tb_ovalid[0]), 32'd1);
    tb_valid[0]  = '0;
    tb_oready[0] = 1'b0;
    cycle();
    check("bp_keep", 32'(tb_out[0]), 32'h22);
    tb_oready[0] = 1'b1;
    cycle();
    check("bp_empty", 32'(tb_ovalid[0]), 32'd0);

    // Round-robin, all channels valid
    tb_data[1]   = 32'h4433_2211;
    tb_valid[1]  = 4'b1111;
    tb_oready[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check($sformatf("rr_grant%0d", i), 32'(tb_grant[1]), 32'(i % 4));
    end
    tb_valid[1] = 4'b0001;
    cycle();
    check("rr_to_ptr1", 32'(tb_grant[1]), 32'd0);
    tb_valid[1] = 4'b1001;
    cycle();
    check("rr_skip_a", 32'(tb_grant[1]), 32'd3);
    cycle();
    check("rr_skip_b", 32'(tb_grant[1]), 32'd0);
    tb_valid[1] = '0;
    cycle();

    // Non-power-of-2 wrap
    tb_data[2]  = 32'h0033_2211;
    tb_valid[2] = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check($sformatf("wrap3_grant%0d", i), 32'(tb_grant[2]), 32'(i % 3));
    end
    tb_valid[2] = '0;
    cycle();

    // Out-of-range select on N=3
    tb_data[3]  = 32'h0077_6655;
    tb_valid[3] = 4'b0111;
    tb_sel[3]   = 2'd3;
    #1;
    check("oor_ready", 32'(tb_iready[3]), 32'h0);
    cycle();
    check("oor_noload", 32'(tb_ovalid[3]), 32'd0);
    tb_sel[3] = 2'd2;
    cycle();
    check("oor_sel2", 32'(tb_out[3]), 32'h77);
    tb_valid[3] = '0;
    cycle();

    // Reset mid-operation (pointer left at 1 above, transfer from ch1 -> 2)
    tb_data[1]  = 32'h0000_5A00;
    tb_valid[1] = 4'b0010;
    cycle();
    check("mid_out", 32'(tb_out[1]), 32'h5A);
    check("mid_grant", 32'(tb_grant[1]), 32'd1);
    tb_valid[1]  = '0;
    tb_oready[1] = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out", 32'(tb_out[1]), 32'h0);
    check("async_valid", 32'(tb_ovalid[1]), 32'h0);
    check("async_grant", 32'(tb_grant[1]), 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n        = 1'b1;
    tb_valid[1]  = 4'b1111;
    tb_oready[1] = 1'b1;
    cycle();
    check("post_rst_grant", 32'(tb_grant[1]), 32'd0);
    idle_all();
    cycle();

    // Randomized traffic on all instances
    repeat (600) begin
      for (int k = 0; k < NCFG; k++) begin
        tb_data[k]   = $urandom;
        tb_valid[k]  = 4'($urandom);
        tb_sel[k]    = 2'($urandom);
        tb_oready[k] = ($urandom_range(0, 3) != 0);
      end
      cycle();
    end

    // Drain and confirm nothing accepted was lost
    idle_all();
    repeat (2) cycle();
    for (int k = 0; k < NCFG; k++)
      check($sformatf("sb_leftover[%0d]", k), 32'(exp_q[k].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
